// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, and a small
// first-word-fall-through FIFO drained by the CPU io path.
module uart_receiver #(
    parameter int WAIT       = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
);

    localparam int HALF = WAIT / 2;
    localparam int CW   = $clog2(WAIT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bitidx, bitidx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          rx_s1, rx_s;
    logic          push, ferr_evt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, pop, push_ok, ovr_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s  <= rx_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shreg  <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bitidx <= bitidx_nxt;
            shreg  <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bitidx_nxt = bitidx;
        shreg_nxt  = shreg;
        push       = 1'b0;
        ferr_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                // A start bit that is gone by mid-bit is a glitch: drop it silently.
                if (cnt == CNT_HALF) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt  = DATA;
                        bitidx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_s, shreg[7:1]};
                    if (bitidx == 3'd7) state_nxt = STOP;
                    else                bitidx_nxt = bitidx + 3'd1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid stop bit so the next start edge is caught early.
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_s) push     = 1'b1;
                    else      ferr_evt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign rd_valid = (count != '0);
    assign full     = (count == FULL_CNT);
    assign pop      = rd_en && rd_valid;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push && (!full || pop);
    assign ovr_evt  = push && full && !pop;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (frame_err && !clr_err) || ferr_evt;
            overrun   <= (overrun && !clr_err) || ovr_evt;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 8 clocks/bit with a 4-entry FIFO.
module tb_uart_receiver;

    localparam int WAIT = 8;
    localparam int NV   = 7;

    logic       clk, reset, uart_rx, rd_en, clr_err;
    logic [7:0] rd_data;
    logic       rd_valid, busy, frame_err, overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       clr;
    } vec_t;

    vec_t vecs [NV];

    uart_receiver #(.WAIT(WAIT), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start bit is driven just after the first edge of the task.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge clk); #1 uart_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (WAIT) @(posedge clk);
            #1 uart_rx = d[i];
        end
        repeat (WAIT) @(posedge clk);
        #1 uart_rx = stop;
        repeat (WAIT) @(posedge clk);
        #1 uart_rx = 1'b1;
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk({name, " valid"}, rd_valid, 1);
        chk({name, " data"}, rd_data, exp);
        rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    initial begin
        int   k;
        logic busy_seen;

        vecs[0] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        reset = 1'b1; uart_rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset rd_valid", rd_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun", overrun, 0);
        chk("reset rd_data", rd_data, 8'h00);
        repeat (2 * WAIT) @(posedge clk);
        #1;

        // Frame 0x5A: busy during the frame and push latency.
        k = 0;
        busy_seen = 1'b0;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                @(posedge clk);
                do begin
                    @(posedge clk); #1 k++;
                    if (busy) busy_seen = 1'b1;
                end while (!rd_valid && k < 200);
            end
        join
        checks++;
        if (k < 77 || k > 79) begin
            errors++;
            $display("FAIL t1 latency: got %0d cycles, expected 78 +/-1", k);
        end
        chk("t1 busy seen", busy_seen, 1);
        chk("t1 busy after", busy, 0);
        chk("t1 frame_err", frame_err, 0);
        chk("t1 overrun", overrun, 0);
        pop_chk("t1 pop", 8'h5A);
        chk("t1 empty", rd_valid, 0);

        // Two-cycle low glitch on the line.
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 uart_rx = 1'b1;
        @(posedge clk); #1;
        chk("t2 busy start", busy, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("t2 busy idle", busy, 0);
        chk("t2 rd_valid", rd_valid, 0);
        chk("t2 frame_err", frame_err, 0);
        chk("t2 overrun", overrun, 0);

        for (int i = 0; i < NV; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            repeat (2 * WAIT) @(posedge clk);
            #1;
            chk($sformatf("v%0d rd_valid", i), rd_valid, vecs[i].exp_valid);
            chk($sformatf("v%0d frame_err", i), frame_err, vecs[i].exp_ferr);
            chk($sformatf("v%0d overrun", i), overrun, 0);
            if (vecs[i].exp_valid) begin
                pop_chk($sformatf("v%0d pop", i), vecs[i].exp_data);
                chk($sformatf("v%0d drained", i), rd_valid, 0);
            end
            if (vecs[i].clr) begin
                pulse_clr();
                chk($sformatf("v%0d cleared", i), frame_err, 0);
            end
        end

        // Five back-to-back frames into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        chk("t4 overrun", overrun, 1);
        chk("t4 frame_err", frame_err, 0);
        for (int i = 1; i <= 4; i++) pop_chk($sformatf("t4 pop%0d", i), 8'(i));
        chk("t4 empty", rd_valid, 0);
        pulse_clr();
        chk("t4 overrun cleared", overrun, 0);

        // Pop on the exact push edge of a fifth byte into a full FIFO.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        fork
            send_frame(8'h8F, 1'b1);
            begin
                @(posedge clk);
                repeat (78) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk); #1 rd_en = 1'b0;
            end
        join
        chk("t5 overrun", overrun, 0);
        pop_chk("t5 pop0", 8'h22);
        pop_chk("t5 pop1", 8'h33);
        pop_chk("t5 pop2", 8'h44);
        pop_chk("t5 pop3", 8'h8F);
        chk("t5 empty", rd_valid, 0);

        // Reset in the middle of frame 0x77 with two bytes queued.
        send_frame(8'h66, 1'b1);
        send_frame(8'h99, 1'b1);
        chk("t6 queued", rd_valid, 1);
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (WAIT) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (WAIT) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (WAIT) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6 busy before reset", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("t6 busy", busy, 0);
        chk("t6 rd_valid", rd_valid, 0);
        chk("t6 frame_err", frame_err, 0);
        repeat (WAIT) @(posedge clk);
        #1;
        send_frame(8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("t6 frame_err after", frame_err, 0);
        pop_chk("t6 pop", 8'h00);
        chk("t6 empty", rd_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive path for mother_board. Counterpart of the existing transmitter; same WAIT (clocks per bit) convention and frame format: 8N1, LSB first, idle high.
- Synchronizes the asynchronous uart_rx pin, detects and validates the start bit, samples data at mid-bit, checks the stop bit, and pushes good bytes into a small first-word-fall-through FIFO.
- The CPU io path drains the FIFO.

Parameters:
- WAIT, 868, clock cycles per UART bit; must be at least 4. HALF = WAIT/2 (integer division).
- FIFO_DEPTH, 4, received-byte buffer entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- uart_rx  input  1  asynchronous serial input, idle high
- rd_en  input  1  pop request from the CPU io path
- rd_data  output  8  FIFO head byte; valid only while rd_valid=1
- rd_valid  output  1  FIFO non-empty
- busy  output  1  receiver FSM not in IDLE
- frame_err  output  1  sticky; a frame ended with stop bit 0
- overrun  output  1  sticky; a good byte was dropped because the FIFO was full
- clr_err  input  1  clears frame_err and overrun

Behaviour:
- Synchronizer:
  - Two flops: rx_s1 then rx_s (the value the FSM uses).
  - Both reset to 1.
  - All FSM decisions use rx_s.
- Counter and bit index:
  - cnt is a bit-period counter sized for WAIT-1.
  - bitidx is 3 bits.
  - shreg is an 8-bit shift register; bits shift in at the MSB and move right, so the byte ends LSB first.
- FSM states: IDLE, START, DATA, STOP. Reset value: IDLE, cnt=0.
  - IDLE: if rx_s=0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt=HALF-1:
    - rx_s=0: go to DATA, cnt=0, bitidx=0.
    - rx_s=1: treat as a glitch and return to IDLE. No flag is set.
  - DATA: at cnt=WAIT-1, sample rx_s into shreg and set cnt=0.
    - If bitidx=7, go to STOP; otherwise bitidx increments.
  - STOP: at cnt=WAIT-1, sample rx_s and go to IDLE on the same edge, so a following start edge can be detected half a bit early.
    - rx_s=1: push shreg into the FIFO.
    - rx_s=0: discard the byte and set frame_err.
- busy = (state != IDLE). Reset value 0.
- Latency: the push edge occurs 2 + HALF + 9*WAIT clock cycles after uart_rx first samples low (±1 for synchronizer phase). rd_valid rises on the cycle after the push edge.
- FIFO:
  - Read pointer, write pointer and count.
  - rd_data is driven combinationally from mem[rd_ptr].
  - Pop occurs on a clock edge with rd_en=1 and rd_valid=1. rd_en while empty is ignored, with no state change.
  - Push while full: byte dropped, overrun set, FIFO unchanged.
  - Push and pop on the same edge: both succeed and count is unchanged. If the FIFO was full, no overrun.
  - Pointers wrap modulo FIFO_DEPTH.
- Flags:
  - frame_err and overrun reset to 0.
  - clr_err=1 clears both on the next edge.
  - If a new error event and clr_err occur on the same edge, the flag ends at 1.
- Reset mid-operation:
  - FSM returns to IDLE; cnt and bitidx go to 0.
  - FIFO is emptied (rd_valid=0 the cycle after reset is sampled).
  - Flags are cleared; synchronizer flops go to 1.
  - A partially received frame is lost. A line still low after reset is treated as a new start bit.
- Reset output values: rd_valid=0, busy=0, frame_err=0, overrun=0. rd_data is don't-care; it is 0 after reset since mem resets to 0.

Test Plan (WAIT=8, FIFO_DEPTH=4):
1. Idle line, then frame 0x5A at 8 clk/bit → busy=1 during the frame. rd_valid=1 and rd_data=0x5A exactly 2+4+72 cycles after the start bit falls (±1). frame_err=0, overrun=0. Pulse rd_en → rd_valid=0.
2. Drive uart_rx low for 2 cycles, then high → busy returns 0 at START's mid-sample. No push; rd_valid stays 0; no flags set.
3. Frame 0xA5 with stop bit driven 0 → frame_err=1, rd_valid=0. Pulse clr_err → frame_err=0. A following good frame 0x3C is received correctly.
4. Frames 0x01..0x05 back-to-back with no reads → overrun=1 after the 5th frame. Reads return 0x01, 0x02, 0x03, 0x04, then rd_valid=0.
5. FIFO holding 4 bytes, rd_en asserted on the exact push edge of a 5th byte 0x8F → overrun=0. Reads return bytes 2, 3, 4, then 0x8F.
6. Assert reset for 1 cycle mid-DATA of frame 0x77 with 2 bytes queued → next cycle busy=0 and rd_valid=0. With the line idle high for one bit time, a new frame 0x00 yields rd_data=0x00 and frame_err=0.
